// File: rtl/ps2_event_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_event_decoder_if
// Description : Key-event valid/ready channel from the decoder to its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_event_decoder_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;

  modport master (
    output ev_valid,
    output ev_code,
    output ev_ext,
    output ev_release,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_code,
    input  ev_ext,
    input  ev_release,
    output ev_ready
  );
endinterface
`default_nettype wire

// File: rtl/ps2_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_event_decoder
// Description : Folds PS/2 set-2 E0/F0 prefixes into key events and queues
//               them in a show-ahead FIFO. Define PS2_PAUSE_FILTER_EN to
//               collapse the 8-byte Pause sequence into a single E1 event.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_event_decoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 code,
  input  logic                       strobe,
  input  logic                       err,
  ps2_event_decoder_if.master        ev,
  output logic                       overflow
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [7:0] C_PFX_EXT = 8'hE0;
  localparam logic [7:0] C_PFX_REL = 8'hF0;
`ifdef PS2_PAUSE_FILTER_EN
  localparam logic [7:0] C_PAUSE   = 8'hE1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_REL    = 3'd2,
    ST_EXTREL = 3'd3
`ifdef PS2_PAUSE_FILTER_EN
    ,
    ST_PAUSE  = 3'd4
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [9:0]      mem_q [DEPTH];
  logic [9:0]      mem_d [DEPTH];
  logic            overflow_q, overflow_d;
`ifdef PS2_PAUSE_FILTER_EN
  logic [2:0]      pause_cnt_q, pause_cnt_d;
`endif

  logic            emit;
  logic [9:0]      emit_entry;
  logic            push;
  logic            pop;
  logic            ev_valid_w;

  // Prefix decoder: entry layout is {ext, rel, code}.
  always_comb begin
    state_d    = state_q;
    emit       = 1'b0;
    emit_entry = {2'b00, code};
`ifdef PS2_PAUSE_FILTER_EN
    pause_cnt_d = pause_cnt_q;
`endif
    if (err) begin
      state_d = ST_IDLE;
    end else if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (code == C_PFX_EXT) begin
            state_d = ST_EXT;
          end else if (code == C_PFX_REL) begin
            state_d = ST_REL;
`ifdef PS2_PAUSE_FILTER_EN
          end else if (code == C_PAUSE) begin
            state_d     = ST_PAUSE;
            pause_cnt_d = 3'd7;
`endif
          end else begin
            emit = 1'b1;
          end
        end
        ST_EXT: begin
          if (code == C_PFX_REL) begin
            state_d = ST_EXTREL;
          end else if (code != C_PFX_EXT) begin
            emit       = 1'b1;
            emit_entry = {2'b10, code};
            state_d    = ST_IDLE;
          end
        end
        ST_REL: begin
          if (code == C_PFX_EXT) begin
            state_d = ST_EXTREL;
          end else if (code != C_PFX_REL) begin
            emit       = 1'b1;
            emit_entry = {2'b01, code};
            state_d    = ST_IDLE;
          end
        end
        ST_EXTREL: begin
          if ((code != C_PFX_EXT) && (code != C_PFX_REL)) begin
            emit       = 1'b1;
            emit_entry = {2'b11, code};
            state_d    = ST_IDLE;
          end
        end
`ifdef PS2_PAUSE_FILTER_EN
        ST_PAUSE: begin
          // Seven trailing bytes are swallowed; the last one releases the event.
          pause_cnt_d = pause_cnt_q - 3'd1;
          if (pause_cnt_q == 3'd1) begin
            emit       = 1'b1;
            emit_entry = {2'b00, C_PAUSE};
            state_d    = ST_IDLE;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign ev_valid_w = (count_q != '0);

  // A full FIFO still accepts an event when the head leaves on the same edge.
  always_comb begin
    pop        = ev_valid_w & ev.ev_ready;
    push       = emit & ((count_q != FULL) | pop);
    overflow_d = emit & ~push;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = emit_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef PS2_PAUSE_FILTER_EN
      pause_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
`ifdef PS2_PAUSE_FILTER_EN
      pause_cnt_q <= pause_cnt_d;
`endif
    end
  end

  assign ev.ev_valid                             = ev_valid_w;
  assign {ev.ev_ext, ev.ev_release, ev.ev_code}  = mem_q[rd_ptr_q];
  assign overflow                                = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_event_decoder
// Description : Directed-vector bench for ps2_event_decoder (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_event_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] code = 8'h00;
  logic       strobe = 1'b0;
  logic       err = 1'b0;
  logic       overflow;

  ps2_event_decoder_if ev_if ();

  ps2_event_decoder #(.DEPTH(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .code     (code),
    .strobe   (strobe),
    .err      (err),
    .ev       (ev_if),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       strobe;
    logic       err;
    logic       ready;
    logic       exp_valid;
    logic [9:0] exp_head;
    logic       exp_ovf;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic [7:0] c, input logic s, input logic e,
                              input logic r, input logic v, input logic [9:0] h,
                              input logic o);
    vec_t t;
    t.code = c; t.strobe = s; t.err = e; t.ready = r;
    t.exp_valid = v; t.exp_head = h; t.exp_ovf = o;
    return t;
  endfunction

  function automatic logic [9:0] head();
    return {ev_if.ev_ext, ev_if.ev_release, ev_if.ev_code};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] c, input logic s, input logic r);
    code = c; strobe = s; err = 1'b0; ev_if.ev_ready = r;
    @(posedge clk);
    #1;
    strobe = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    code = v.code; strobe = v.strobe; err = v.err; ev_if.ev_ready = v.ready;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    err    = 1'b0;
    check({tag, " valid"}, 32'(ev_if.ev_valid), 32'(v.exp_valid));
    if (v.exp_valid) check({tag, " head"}, 32'(head()), 32'(v.exp_head));
    check({tag, " overflow"}, 32'(overflow), 32'(v.exp_ovf));
  endtask

  vec_t tbl[$];
  vec_t ptbl[$];
  logic [9:0] drain_a [4];
  logic [9:0] drain_b [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, wanted completion");
    $fatal(1);
  end

  initial begin
    // Decode table: {code, strobe, err, ready, exp_valid, exp_head, exp_ovf}
    tbl.push_back(mk(8'h1C, 1, 0, 1, 1, 10'h01C, 0));
    tbl.push_back(mk(8'hF0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'h1C, 1, 0, 1, 1, 10'h11C, 0));
    tbl.push_back(mk(8'hE0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'h75, 1, 0, 1, 1, 10'h275, 0));
    tbl.push_back(mk(8'hE0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'hF0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'h75, 1, 0, 1, 1, 10'h375, 0));
    tbl.push_back(mk(8'hE0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'h00, 0, 1, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'h29, 1, 0, 0, 1, 10'h029, 0));
    tbl.push_back(mk(8'h00, 0, 0, 0, 1, 10'h029, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'hE0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'h33, 1, 1, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'h33, 1, 0, 1, 1, 10'h033, 0));
    tbl.push_back(mk(8'hF0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'hF0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'h12, 1, 0, 1, 1, 10'h112, 0));
    tbl.push_back(mk(8'hE0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'hE0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'hF0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'hE0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'h6B, 1, 0, 1, 1, 10'h36B, 0));
    tbl.push_back(mk(8'hF0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'hE0, 1, 0, 1, 0, 10'h000, 0));
    tbl.push_back(mk(8'h4A, 1, 0, 1, 1, 10'h34A, 0));
    tbl.push_back(mk(8'h1C, 1, 0, 1, 1, 10'h01C, 0));
    tbl.push_back(mk(8'h1B, 1, 0, 1, 1, 10'h01B, 0));
    tbl.push_back(mk(8'h23, 1, 0, 1, 1, 10'h023, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 10'h000, 0));

    // Pause sequence E1 14 77 E1 F0 14 F0 77, consumer always ready
`ifdef PS2_PAUSE_FILTER_EN
    ptbl.push_back(mk(8'hE1, 1, 0, 1, 0, 10'h000, 0));
    ptbl.push_back(mk(8'h14, 1, 0, 1, 0, 10'h000, 0));
    ptbl.push_back(mk(8'h77, 1, 0, 1, 0, 10'h000, 0));
    ptbl.push_back(mk(8'hE1, 1, 0, 1, 0, 10'h000, 0));
    ptbl.push_back(mk(8'hF0, 1, 0, 1, 0, 10'h000, 0));
    ptbl.push_back(mk(8'h14, 1, 0, 1, 0, 10'h000, 0));
    ptbl.push_back(mk(8'hF0, 1, 0, 1, 0, 10'h000, 0));
    ptbl.push_back(mk(8'h77, 1, 0, 1, 1, 10'h0E1, 0));
    ptbl.push_back(mk(8'h00, 0, 0, 1, 0, 10'h000, 0));
`else
    ptbl.push_back(mk(8'hE1, 1, 0, 1, 1, 10'h0E1, 0));
    ptbl.push_back(mk(8'h14, 1, 0, 1, 1, 10'h014, 0));
    ptbl.push_back(mk(8'h77, 1, 0, 1, 1, 10'h077, 0));
    ptbl.push_back(mk(8'hE1, 1, 0, 1, 1, 10'h0E1, 0));
    ptbl.push_back(mk(8'hF0, 1, 0, 1, 0, 10'h000, 0));
    ptbl.push_back(mk(8'h14, 1, 0, 1, 1, 10'h114, 0));
    ptbl.push_back(mk(8'hF0, 1, 0, 1, 0, 10'h000, 0));
    ptbl.push_back(mk(8'h77, 1, 0, 1, 1, 10'h177, 0));
    ptbl.push_back(mk(8'h00, 0, 0, 1, 0, 10'h000, 0));
`endif

    drain_a = '{10'h016, 10'h01E, 10'h026, 10'h025};
    drain_b = '{10'h01E, 10'h026, 10'h025, 10'h02E};

    // Reset state
    ev_if.ev_ready = 1'b0;
    @(posedge clk);
    #1;
    check("reset valid", 32'(ev_if.ev_valid), 32'd0);
    check("reset head", 32'(head()), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Overflow on the fifth make code, then ordered drain
    step(8'h16, 1, 0);
    step(8'h1E, 1, 0);
    step(8'h26, 1, 0);
    step(8'h25, 1, 0);
    check("fill overflow", 32'(overflow), 32'd0);
    step(8'h2E, 1, 0);
    check("drop overflow", 32'(overflow), 32'd1);
    step(8'h00, 0, 0);
    check("drop overflow pulse", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_a[%0d] valid", i), 32'(ev_if.ev_valid), 32'd1);
      check($sformatf("drain_a[%0d] head", i), 32'(head()), 32'(drain_a[i]));
      step(8'h00, 0, 1);
    end
    check("drain_a empty", 32'(ev_if.ev_valid), 32'd0);

    // Full FIFO with push and pop on the same edge
    step(8'h16, 1, 0);
    step(8'h1E, 1, 0);
    step(8'h26, 1, 0);
    step(8'h25, 1, 0);
    step(8'h2E, 1, 1);
    check("full push+pop overflow", 32'(overflow), 32'd0);
    check("full push+pop head", 32'(head()), 32'h01E);
    step(8'h36, 1, 0);
    check("still full overflow", 32'(overflow), 32'd1);
    step(8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_b[%0d] valid", i), 32'(ev_if.ev_valid), 32'd1);
      check($sformatf("drain_b[%0d] head", i), 32'(head()), 32'(drain_b[i]));
      step(8'h00, 0, 1);
    end
    check("drain_b empty", 32'(ev_if.ev_valid), 32'd0);

    // Asynchronous reset with events queued and an E0 prefix pending
    step(8'h16, 1, 0);
    step(8'h1E, 1, 0);
    step(8'hE0, 1, 0);
    check("pre-reset valid", 32'(ev_if.ev_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset valid", 32'(ev_if.ev_valid), 32'd0);
    check("async reset head", 32'(head()), 32'd0);
    check("async reset overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(8'h29, 1, 1);
    check("post-reset valid", 32'(ev_if.ev_valid), 32'd1);
    check("post-reset head", 32'(head()), 32'h029);
    step(8'h00, 0, 1);
    check("post-reset empty", 32'(ev_if.ev_valid), 32'd0);

    foreach (ptbl[i]) apply(ptbl[i], $sformatf("pause[%0d]", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
